seq_sll_shifter: RTL and testbench

Iterative logical left shifter, the left-shift counterpart of the combinational `b32_SRL` right shifter in the ALU shift path. It accepts an operand and shift amount over a valid/ready handshake and resolves one shift-amount bit per cycle, shifting by 2^k on cycle k. It returns `Z = X << S` after a fixed latency. It serves multi-cycle ALU configurations where a full single-cycle barrel shifter is too large or too slow.

---
 rtl/seq_sll_shifter_pkg.sv | 18 +
 rtl/sll_stage.sv | 21 ++
 rtl/seq_sll_shifter.sv | 96 +++++++++
 tb/tb_seq_sll_shifter.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/seq_sll_shifter_pkg.sv
//------------------------------------------------------------------------------
// Module  : seq_sll_shifter_pkg
// Brief   : Shared state encoding for the iterative left shifter.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package seq_sll_shifter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } sll_state_t;

endpackage

`default_nettype wire

// File: rtl/sll_stage.sv
//------------------------------------------------------------------------------
// Module  : sll_stage
// Brief   : Combinational stage: shifts acc left by 2^k, zero fill.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sll_stage #(
   parameter int N  = 32,
   parameter int KW = 3
) (
   input  logic [N-1:0]  acc_i,
   input  logic [KW-1:0] k_i,
   output logic [N-1:0]  acc_o
);

   assign acc_o = acc_i << (32'd1 << k_i);

endmodule

`default_nettype wire

// File: rtl/seq_sll_shifter.sv
//------------------------------------------------------------------------------
// Module  : seq_sll_shifter
// Brief   : Iterative logical left shifter, one shift-amount bit per cycle.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seq_sll_shifter
   import seq_sll_shifter_pkg::*;
#(
   parameter int N     = 32,
   parameter int LOG2N = 5
) (
   input  logic          clk,
   input  logic          rstb,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  X,
   input  logic [31:0]   S,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [N-1:0]  Z
);

   localparam int CW = (LOG2N > 1) ? $clog2(LOG2N) : 1;
   localparam logic [CW-1:0] C_LAST = CW'(LOG2N - 1);

   sll_state_t       state_q, state_d;
   logic [N-1:0]     acc_q, acc_d;
   logic [LOG2N-1:0] amt_q, amt_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [N-1:0]     stage_out;
   logic             overflow;

   // Any amount bit at or above LOG2N means the whole operand shifts out.
   assign overflow = |S[31:LOG2N];

   sll_stage #(
      .N  (N),
      .KW (CW)
   ) u_stage (
      .acc_i (acc_q),
      .k_i   (cnt_q),
      .acc_o (stage_out)
   );

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         amt_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         amt_q   <= amt_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      amt_d   = amt_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               acc_d   = overflow ? '0 : X;
               amt_d   = S[LOG2N-1:0];
               cnt_d   = '0;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (amt_q[cnt_q]) acc_d = stage_out;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == C_LAST) begin
               cnt_d   = '0;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign in_ready  = (state_q == ST_IDLE) && rstb;
   assign out_valid = (state_q == ST_DONE);
   assign Z         = acc_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_sll_shifter.sv
//------------------------------------------------------------------------------
// Module  : tb_seq_sll_shifter
// Brief   : Self-checking bench for seq_sll_shifter against a shift model.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_seq_sll_shifter;

   localparam int N     = 32;
   localparam int LOG2N = 5;

   logic          clk = 1'b0;
   logic          rstb;
   logic          in_valid;
   logic          in_ready;
   logic [N-1:0]  X;
   logic [31:0]   S;
   logic          out_valid;
   logic          out_ready;
   logic [N-1:0]  Z;

   int n_tests = 0;
   int n_fail  = 0;
   int hs_cnt  = 0;
   int exp_hs  = 0;

   seq_sll_shifter #(
      .N     (N),
      .LOG2N (LOG2N)
   ) dut (
      .clk       (clk),
      .rstb      (rstb),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .X         (X),
      .S         (S),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Z         (Z)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rstb && out_valid && out_ready) hs_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] s);
      if (s >= 32'(N)) return '0;
      return x << s;
   endfunction

   // One full operation; hold = cycles of backpressure in DONE.
   task automatic do_op(input logic [31:0] x, input logic [31:0] s, input int hold);
      int lat;
      logic [31:0] exp;
      exp = model(x, s);
      @(negedge clk);
      check("in_ready_idle", 32'(in_ready), 32'd1);
      X = x; S = s; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      X = $urandom; S = $urandom;
      lat = 0;
      while (!out_valid && lat < 20) begin
         check("in_ready_busy", 32'(in_ready), 32'd0);
         @(posedge clk); #1;
         lat++;
      end
      check("latency", 32'(lat), 32'(LOG2N));
      check("result", Z, exp);
      for (int i = 0; i < hold; i++) begin
         if (i == 2) begin
            in_valid = 1'b1; X = 32'd1; S = 32'd1;
         end
         @(posedge clk); #1;
         in_valid = 1'b0;
         check("bp_valid", 32'(out_valid), 32'd1);
         check("bp_z", Z, exp);
         check("bp_in_ready", 32'(in_ready), 32'd0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      exp_hs++;
      check("post_hs_valid", 32'(out_valid), 32'd0);
      check("post_hs_ready", 32'(in_ready), 32'd1);
   endtask

   localparam logic [31:0] XS [8] = '{32'd8, 32'd12, 32'd14, 32'd7,
                                     32'hFFFF_FFF1, 32'hFFFF_FFFD,
                                     32'hFFFF_FFFF, 32'hFFFF_FFF6};
   localparam logic [31:0] SS [8] = '{32'd0, 32'd1, 32'd2, 32'd3,
                                     32'd7, 32'd15, 32'd23, 32'd31};

   initial begin
      rstb = 1'b0; in_valid = 1'b0; out_ready = 1'b0; X = '0; S = '0;
      #12;
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_z", Z, 32'd0);
      @(negedge clk); rstb = 1'b1; #1;
      check("rel_in_ready", 32'(in_ready), 32'd1);

      do_op(32'd8, 32'd1, 0);
      do_op(32'hFFFF_FFF1, 32'd31, 0);
      do_op(32'hFFFF_FFF6, 32'd3, 0);
      do_op(32'd12, 32'd0, 0);
      do_op(32'hFFFF_FFFF, 32'd32, 0);
      do_op(32'hFFFF_FFFF, 32'h0000_0100, 0);
      do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

      // Backpressure with an ignored in_valid pulse, then no queued op.
      do_op(32'd7, 32'd2, 10);
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         check("no_queued_op", 32'(out_valid), 32'd0);
      end

      // Reset during SHIFT cycle 2 aborts the op.
      @(negedge clk);
      X = 32'd14; S = 32'd3; in_valid = 1'b1;
      @(posedge clk); #1; in_valid = 1'b0;
      @(posedge clk); @(posedge clk); #2;
      rstb = 1'b0; #1;
      check("abort_valid", 32'(out_valid), 32'd0);
      check("abort_z", Z, 32'd0);
      check("abort_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk); rstb = 1'b1;
      for (int i = 0; i < 7; i++) begin
         @(posedge clk); #1;
         check("no_stale_valid", 32'(out_valid), 32'd0);
      end
      do_op(32'd7, 32'd3, 0);

      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++)
            do_op(XS[i], SS[j], 0);

      for (int i = 0; i < 40; i++) begin
         logic [31:0] rs;
         rs = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
         do_op($urandom, rs, $urandom_range(0, 2));
      end

      check("handshake_count", 32'(hs_cnt), 32'(exp_hs));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
